// File: rtl/seg_pkg.sv
// Shared definitions for the 8-digit multiplexed hex display bus.
// Used by the scan driver and by the receive-side decoder.
package seg_pkg;

    localparam int DIGITS  = 8;
    localparam int AN_W    = 3;
    localparam int DIGIT_W = 4;
    localparam int WORD_W  = 32;

    typedef enum logic {
        SYNC    = 1'b0,
        COLLECT = 1'b1
    } scan_state_t;

    // Index of the digit accepted just before idx; wraps 0 -> DIGITS-1.
    function automatic logic [AN_W-1:0] prev_idx(input logic [AN_W-1:0] idx);
        return idx - AN_W'(1);
    endfunction

    // Bit offset of a digit nibble inside the word.
    function automatic logic [4:0] nib_lsb(input logic [AN_W-1:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// Dwell filter for the scanned (an,data) stream: a pair must stay unchanged for
// STABLE_CYCLES consecutive samples before it is accepted, once per dwell.
module seg_stable_filter
    import seg_pkg::*;
#(
    parameter  int STABLE_CYCLES = 4,
    localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [AN_W-1:0]    an,
    input  logic [DIGIT_W-1:0] data,
    output logic               acc_pulse,
    output logic [AN_W-1:0]    acc_an,
    output logic [DIGIT_W-1:0] acc_data
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(STABLE_CYCLES - 2);

    logic [AN_W-1:0]    prev_an;
    logic [DIGIT_W-1:0] prev_data;
    logic [CNT_W-1:0]   cnt;
    logic               same;

    assign same = (an == prev_an) && (data == prev_data);

    // The pulse is registered alongside cnt, so it is high exactly in the
    // cycle where cnt sits at CNT_LAST for the first time; saturation keeps it single.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_an   <= '0;
            prev_data <= '0;
            cnt       <= '0;
            acc_pulse <= 1'b0;
        end else begin
            prev_an   <= an;
            prev_data <= data;
            acc_pulse <= same && (cnt == CNT_PRE);
            if (!same) begin
                cnt <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // During the accept cycle the previous-sample registers hold the dwelled pair.
    assign acc_an   = prev_an;
    assign acc_data = prev_data;

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of the multiplexed hex display bus: filters, order-checks and
// rebuilds the 32-bit word. Optional input synchronizer under SEG_INSYNC_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// SYNC    | waiting for an accepted digit 0 to start a frame
// COLLECT | gathering digits in order; exp_idx is the next digit wanted
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter  int STABLE_CYCLES = 4,
    localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [AN_W-1:0]    seg_an,
    input  logic [DIGIT_W-1:0] seg_data,
    output logic [WORD_W-1:0]  word_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               seq_err_o,
    output logic               overrun_o
);

    localparam logic [AN_W-1:0] LAST_DIGIT = AN_W'(DIGITS - 1);

    logic [AN_W-1:0]    an_s;
    logic [DIGIT_W-1:0] data_s;

`ifdef SEG_INSYNC_EN
    logic [AN_W-1:0]    an_meta;
    logic [DIGIT_W-1:0] data_meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_meta   <= '0;
            data_meta <= '0;
            an_s      <= '0;
            data_s    <= '0;
        end else begin
            an_meta   <= seg_an;
            data_meta <= seg_data;
            an_s      <= an_meta;
            data_s    <= data_meta;
        end
    end
`else
    assign an_s   = seg_an;
    assign data_s = seg_data;
`endif

    logic               acc_pulse;
    logic [AN_W-1:0]    acc_an;
    logic [DIGIT_W-1:0] acc_data;

    seg_stable_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .an        (an_s),
        .data      (data_s),
        .acc_pulse (acc_pulse),
        .acc_an    (acc_an),
        .acc_data  (acc_data)
    );

    scan_state_t       state, state_nxt;
    logic [AN_W-1:0]   exp_idx, exp_nxt;
    logic [WORD_W-1:0] shadow, shadow_nxt;
    logic              err_nxt;
    logic              frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SYNC;
            exp_idx <= '0;
            shadow  <= '0;
        end else begin
            state   <= state_nxt;
            exp_idx <= exp_nxt;
            shadow  <= shadow_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        exp_nxt    = exp_idx;
        shadow_nxt = shadow;
        err_nxt    = 1'b0;
        frame_done = 1'b0;
        if (acc_pulse) begin
            unique case (state)
                SYNC: begin
                    if (acc_an == '0) begin
                        shadow_nxt[nib_lsb(acc_an) +: DIGIT_W] = acc_data;
                        exp_nxt   = AN_W'(1);
                        state_nxt = COLLECT;
                    end
                end
                COLLECT: begin
                    if (acc_an == exp_idx) begin
                        shadow_nxt[nib_lsb(acc_an) +: DIGIT_W] = acc_data;
                        exp_nxt    = exp_idx + AN_W'(1);
                        frame_done = (acc_an == LAST_DIGIT);
                    end else if (acc_an == prev_idx(exp_idx)) begin
                        // The driver changed data while still on this digit.
                        shadow_nxt[nib_lsb(acc_an) +: DIGIT_W] = acc_data;
                    end else begin
                        err_nxt = 1'b1;
                        if (acc_an == '0) begin
                            shadow_nxt[nib_lsb(acc_an) +: DIGIT_W] = acc_data;
                            exp_nxt = AN_W'(1);
                        end else begin
                            exp_nxt   = '0;
                            state_nxt = SYNC;
                        end
                    end
                end
                default: begin
                    exp_nxt   = '0;
                    state_nxt = SYNC;
                end
            endcase
        end
    end

    // A completed frame that finds the port still occupied is dropped, never merged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_o    <= '0;
            valid_o   <= 1'b0;
            seq_err_o <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            seq_err_o <= err_nxt;
            if (frame_done) begin
                if (!valid_o || ready_i) begin
                    word_o  <= shadow_nxt;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: directed scan streams push expected
// words; a negedge monitor pops and compares on every valid/ready handshake.
module tb_seg_scan_decoder;

    localparam int DWELL = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  seg_an;
    logic [3:0]  seg_data;
    logic [31:0] word_o;
    logic        valid_o;
    logic        ready_i;
    logic        seq_err_o;
    logic        overrun_o;

    int n_cmp = 0;
    int n_mis = 0;
    int err_seen = 0;
    logic [31:0] exp_q[$];

    seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_an    (seg_an),
        .seg_data  (seg_data),
        .word_o    (word_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .seq_err_o (seq_err_o),
        .overrun_o (overrun_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_digit(input logic [2:0] a, input logic [3:0] d, input int n);
        seg_an   = a;
        seg_data = d;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sweep(input logic [31:0] w, input int first, input int last);
        for (int i = first; i <= last; i++)
            drive_digit(3'(i), w[4*i +: 4], DWELL);
    endtask

    // Monitor: handshakes pop the scoreboard, seq_err pulses are counted.
    always @(negedge clk) begin
        if (rst_n) begin
            if (seq_err_o) err_seen++;
            if (valid_o && ready_i) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL unexpected_word: got %h, expected no word", word_o);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (word_o !== e) begin
                        n_mis++;
                        $display("FAIL word: got %h, expected %h", word_o, e);
                    end
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        seg_an   = '0;
        seg_data = '0;
        ready_i  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_word", word_o, 32'h0);
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_seq_err", 32'(seq_err_o), 32'h0);
        check("rst_overrun", 32'(overrun_o), 32'h0);
        rst_n = 1'b1;

        // 1: steady scanning, three sweeps
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(32'h23000020);
            sweep(32'h23000020, 0, 7);
        end

        // 2: digit 3 glitches for 2 clks, then the driver falls back to digit 2
        exp_q.push_back(32'h23000020);
        sweep(32'h23000020, 0, 2);
        drive_digit(3'd3, 4'h0, 2);
        drive_digit(3'd2, 4'h0, DWELL);
        sweep(32'h23000020, 3, 7);
        check("no_seq_err_t1_t2", 32'(err_seen), 32'd0);

        // 3: order 0,1,2,5 is an error, next full sweep recovers
        sweep(32'h89ABCDEF, 0, 2);
        drive_digit(3'd5, 4'hA, DWELL);
        exp_q.push_back(32'h89ABCDEF);
        sweep(32'h89ABCDEF, 0, 7);
        check("seq_err_count_t3", 32'(err_seen), 32'd1);

        // 4: consumer stalled across two extra frames
        ready_i = 1'b0;
        exp_q.push_back(32'h12345678);
        sweep(32'h12345678, 0, 7);
        sweep(32'h12345678, 0, 7);
        sweep(32'hCAFEBABE, 0, 7);
        check("held_word", word_o, 32'h12345678);
        check("held_valid", 32'(valid_o), 32'h1);
        check("overrun_set", 32'(overrun_o), 32'h1);
        ready_i = 1'b1;
        exp_q.push_back(32'hCAFEBABE);
        sweep(32'hCAFEBABE, 0, 7);
        check("overrun_sticky", 32'(overrun_o), 32'h1);

        // 5: reset in the middle of a frame while a word is pending
        ready_i = 1'b0;
        sweep(32'h0F1E2D3C, 0, 7);
        check("pending_word", word_o, 32'h0F1E2D3C);
        sweep(32'h55AA55AA, 0, 4);
        rst_n = 1'b0;
        #1;
        check("midrst_word", word_o, 32'h0);
        check("midrst_valid", 32'(valid_o), 32'h0);
        check("midrst_overrun", 32'(overrun_o), 32'h0);
        check("midrst_seq_err", 32'(seq_err_o), 32'h0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        ready_i = 1'b1;
        sweep(32'h55AA55AA, 5, 7);
        exp_q.push_back(32'h55AA55AA);
        sweep(32'h55AA55AA, 0, 7);

        repeat (20) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("seq_err_total", 32'(err_seen), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
